// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 device-to-host frame receiver.
// Synchronizes ps2_clk/ps2_data and decodes 11-bit frames:
// start(0), 8 data bits LSB first, odd parity, stop(1).
// Publishes a 32-bit status word (last code, prefix flags, good-code count,
// last-frame error) and pulses code_valid for each new scan code.
// Partial frames are abandoned after TIMEOUT_CYCLES clk cycles without a
// ps2_clk falling edge.
// Optional build macro PS2_BREAK_DECODE_EN: treats 0xF0 (release) and
// 0xE0 (extended) as prefixes that arm flags for the next scan code
// instead of being reported as codes themselves.
module ps2_receiver #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] dataForPS2,
  output logic        code_valid
);

  // Timeout counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronizer chains; index 0 faces the asynchronous pin.
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;

  logic w_clk_s;
  logic w_data_s;
  logic w_fall;

  // Frame state
  state_t           r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_parity;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Published status
  logic [7:0]       r_code;
  logic             r_rel;
  logic             r_ext;
  logic [7:0]       r_count;
  logic             r_err;
  logic             r_code_valid;

  // Armed prefix flags waiting for the next scan code
  logic             r_rel_arm;
  logic             r_ext_arm;

  logic w_parity_ok;
  logic w_frame_good;
  logic w_timeout;
  logic w_is_rel_prefix;
  logic w_is_ext_prefix;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First synchronizer stage samples the raw PS/2 pins; idles high.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_clk_sync[gi]  <= 1'b1;
            r_data_sync[gi] <= 1'b1;
          end else begin
            r_clk_sync[gi]  <= ps2_clk;
            r_data_sync[gi] <= ps2_data;
          end
        end
      end else begin : g_rest
        // Later synchronizer stages resolve metastability from the stage before.
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            r_clk_sync[gi]  <= 1'b1;
            r_data_sync[gi] <= 1'b1;
          end else begin
            r_clk_sync[gi]  <= r_clk_sync[gi-1];
            r_data_sync[gi] <= r_data_sync[gi-1];
          end
        end
      end
    end
  endgenerate

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Previous synchronized ps2_clk, used to spot the 1 -> 0 transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_fall = r_clk_prev & ~w_clk_s;

  // Odd parity across the 8 data bits and the parity bit.
  assign w_parity_ok  = ^{r_shift, r_parity};
  // Evaluated only in S_STOP on a fall, where w_data_s is the stop bit.
  assign w_frame_good = w_parity_ok & w_data_s;
  assign w_timeout    = (r_tmo_cnt == TIMEOUT_LAST);

`ifdef PS2_BREAK_DECODE_EN
  assign w_is_rel_prefix = (r_shift == 8'hF0);
  assign w_is_ext_prefix = (r_shift == 8'hE0);
`else
  // Prefix decoding disabled: every good byte is a scan code, and the
  // arm flags never set, so [9:8] stay 0.
  assign w_is_rel_prefix = 1'b0;
  assign w_is_ext_prefix = 1'b0;
`endif

  // Frame FSM plus all status registers; a fall always wins over timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_parity     <= 1'b0;
      r_tmo_cnt    <= '0;
      r_code       <= 8'h00;
      r_rel        <= 1'b0;
      r_ext        <= 1'b0;
      r_count      <= 8'h00;
      r_err        <= 1'b0;
      r_code_valid <= 1'b0;
      r_rel_arm    <= 1'b0;
      r_ext_arm    <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;

      if (r_state == S_IDLE) begin
        r_tmo_cnt <= '0;
        if (w_fall && !w_data_s) begin
          // Start bit: begin a fresh frame with all bit state cleared.
          r_state   <= S_DATA;
          r_shift   <= 8'h00;
          r_bit_cnt <= 3'd0;
          r_parity  <= 1'b0;
        end
      end else if (w_fall) begin
        r_tmo_cnt <= '0;
        case (r_state)
          S_DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (w_frame_good) begin
              r_err <= 1'b0;
              if (w_is_rel_prefix) begin
                r_rel_arm <= 1'b1;
              end else if (w_is_ext_prefix) begin
                r_ext_arm <= 1'b1;
              end else begin
                r_code       <= r_shift;
                r_rel        <= r_rel_arm;
                r_ext        <= r_ext_arm;
                r_rel_arm    <= 1'b0;
                r_ext_arm    <= 1'b0;
                r_count      <= r_count + 8'd1;
                r_code_valid <= 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end else if (w_timeout) begin
        // Device went quiet mid-frame: drop it and flag the error.
        r_state   <= S_IDLE;
        r_tmo_cnt <= '0;
        r_err     <= 1'b1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign dataForPS2 = {r_err, 7'b0, r_count, 6'b0, r_ext, r_rel, r_code};
  assign code_valid = r_code_valid;

endmodule
